// File: rtl/fp51_pwm_multi.sv
// fp51_pwm_multi
// Multi-channel PWM generator behind a five-register 8051-style SFR window.
// CTRL (EN/MODE/IE), SEL, DATA_L, DATA_H and STAT sit at BASE_ADDR+0..+4.
// SEL picks which shadow register DATA_L/DATA_H access: PERIOD, PRESCALE,
// POLARITY or DUTY[k]. Shadows reach the running copies at every period
// boundary, or at once when EN is switched on.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   WB_WR_STB_I/WE_I/ADR_I/DAT_I      SFR write request
//   WB_WR_ACK_O                       write acknowledge (one cycle, next clock)
//   WB_RD_STB_I/ADR_I                 SFR read request
//   WB_RD_DAT_O, WB_RD_ACK_O          read data and acknowledge (next clock)
//   pwm_out[NUM_CH-1:0]               PWM outputs, bit k = channel k
//   period_int                        level interrupt, STAT.PF & CTRL.IE
module fp51_pwm_multi #(
    parameter int         NUM_CH    = 4,
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] BASE_ADDR = 8'hD8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              WB_WR_STB_I,
    input  logic              WB_WR_WE_I,
    input  logic [7:0]        WB_WR_ADR_I,
    input  logic [7:0]        WB_WR_DAT_I,
    output logic              WB_WR_ACK_O,
    input  logic              WB_RD_STB_I,
    input  logic [7:0]        WB_RD_ADR_I,
    output logic [7:0]        WB_RD_DAT_O,
    output logic              WB_RD_ACK_O,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_int
);
    localparam int CW = CNT_WIDTH;

    // Register state
    logic              ctrl_en, ctrl_mode, ctrl_ie;
    logic [7:0]        sel, staging, prescale_sh, pre_cnt;
    logic [CW-1:0]     period_sh, act_period;
    logic [NUM_CH-1:0] pol_sh, act_pol;
    logic [CW-1:0]     duty_sh  [NUM_CH];
    logic [CW-1:0]     act_duty [NUM_CH];
    logic              act_mode, pf, dir_up;

    // Address decode (offset arithmetic wraps, so any BASE_ADDR works)
    logic [7:0]  wr_off, rd_off;
    logic        wr_hit, rd_hit;
    logic        wr_ctrl, wr_sel, wr_dl, wr_dh, wr_stat;
    logic        en_set, en_clr;
    logic [15:0] wr_word;
    logic [CW-1:0] commit;

    assign wr_off  = WB_WR_ADR_I - BASE_ADDR;
    assign rd_off  = WB_RD_ADR_I - BASE_ADDR;
    assign wr_hit  = WB_WR_STB_I && WB_WR_WE_I && (wr_off < 8'd5);
    assign rd_hit  = WB_RD_STB_I && (rd_off < 8'd5);
    assign wr_ctrl = wr_hit && (wr_off == 8'd0);
    assign wr_sel  = wr_hit && (wr_off == 8'd1);
    assign wr_dl   = wr_hit && (wr_off == 8'd2);
    assign wr_dh   = wr_hit && (wr_off == 8'd3);
    assign wr_stat = wr_hit && (wr_off == 8'd4);
    assign en_set  = wr_ctrl && WB_WR_DAT_I[0] && !ctrl_en;
    assign en_clr  = wr_ctrl && !WB_WR_DAT_I[0];
    assign wr_word = {WB_WR_DAT_I, staging};
    assign commit  = wr_word[CW-1:0];

    // Shadow selected by SEL, zero-extended to 16 bits for byte reads
    logic [15:0] sh_val;
    always_comb begin
        sh_val = '0;
        if (sel == 8'd0)      sh_val[CW-1:0]     = period_sh;
        else if (sel == 8'd1) sh_val[7:0]        = prescale_sh;
        else if (sel == 8'd2) sh_val[NUM_CH-1:0] = pol_sh;
        for (int k = 0; k < NUM_CH; k++)
            if (sel == 8'(k + 3)) sh_val[CW-1:0] = duty_sh[k];
    end

    logic [7:0] rd_mux;
    always_comb begin
        case (rd_off)
            8'd0:    rd_mux = {5'b0, ctrl_ie, ctrl_mode, ctrl_en};
            8'd1:    rd_mux = sel;
            8'd2:    rd_mux = sh_val[7:0];
            8'd3:    rd_mux = sh_val[15:8];
            8'd4:    rd_mux = {7'b0, pf};
            default: rd_mux = 8'h00;
        endcase
    end

    // Prescaler tick and next counter value
    logic          tick, boundary, dir_nxt;
    logic [CW-1:0] cnt_p0, cnt_nxt;

    assign tick = ctrl_en && (pre_cnt >= prescale_sh);

    always_comb begin
        cnt_nxt = cnt_p0;
        dir_nxt = dir_up;
        if (!act_mode) begin
            cnt_nxt = (cnt_p0 >= act_period) ? '0 : cnt_p0 + CW'(1);
        end else if (dir_up) begin
            if (cnt_p0 >= act_period) begin
                // Top reached: turn around (PERIOD = 0 simply stays at 0)
                cnt_nxt = (act_period == '0) ? '0 : cnt_p0 - CW'(1);
                dir_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt_p0 + CW'(1);
            end
        end else begin
            cnt_nxt = cnt_p0 - CW'(1);
        end
        // Arriving at 0 always restarts the up-count
        if (cnt_nxt == '0) dir_nxt = 1'b1;
    end

    assign boundary = tick && (cnt_nxt == '0);

    // SFR registers and shadows
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {ctrl_ie, ctrl_mode, ctrl_en} <= 3'b000;
            sel         <= '0;
            staging     <= '0;
            period_sh   <= '0;
            prescale_sh <= '0;
            pol_sh      <= '0;
            for (int k = 0; k < NUM_CH; k++) duty_sh[k] <= '0;
        end else begin
            if (wr_ctrl) {ctrl_ie, ctrl_mode, ctrl_en} <= WB_WR_DAT_I[2:0];
            if (wr_sel)  sel     <= WB_WR_DAT_I;
            if (wr_dl)   staging <= WB_WR_DAT_I;
            if (wr_dh) begin
                if (sel == 8'd0)      period_sh   <= commit;
                else if (sel == 8'd1) prescale_sh <= wr_word[7:0];
                else if (sel == 8'd2) pol_sh      <= wr_word[NUM_CH-1:0];
                for (int k = 0; k < NUM_CH; k++)
                    if (sel == 8'(k + 3)) duty_sh[k] <= commit;
            end
        end
    end

    // Active copies: reloaded at each period boundary or when EN turns on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_period <= '0;
            act_pol    <= '0;
            act_mode   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) act_duty[k] <= '0;
        end else if (boundary || en_set) begin
            act_period <= period_sh;
            act_pol    <= pol_sh;
            act_mode   <= en_set ? WB_WR_DAT_I[1] : ctrl_mode;
            for (int k = 0; k < NUM_CH; k++) act_duty[k] <= duty_sh[k];
        end
    end

    // Period flag: a set event wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        pf <= 1'b0;
        else if (boundary)                   pf <= 1'b1;
        else if (wr_stat && WB_WR_DAT_I[0])  pf <= 1'b0;
    end

    // Stage p0: prescaler and period counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            cnt_p0  <= '0;
            dir_up  <= 1'b1;
        end else if (!ctrl_en || en_clr) begin
            pre_cnt <= '0;
            cnt_p0  <= '0;
            dir_up  <= 1'b1;
        end else begin
            pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
            if (tick) begin
                cnt_p0 <= cnt_nxt;
                dir_up <= dir_nxt;
            end
        end
    end

    // Stage p1: registered duty compare
    logic [NUM_CH-1:0] raw_p1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_p1 <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) raw_p1[k] <= (cnt_p0 < act_duty[k]);
        end
    end

    // Bus responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            WB_WR_ACK_O <= 1'b0;
            WB_RD_ACK_O <= 1'b0;
            WB_RD_DAT_O <= 8'h00;
        end else begin
            WB_WR_ACK_O <= wr_hit;
            WB_RD_ACK_O <= rd_hit;
            WB_RD_DAT_O <= rd_hit ? rd_mux : 8'h00;
        end
    end

    assign pwm_out    = ctrl_en ? (raw_p1 ^ act_pol) : act_pol;
    assign period_int = pf && ctrl_ie;

endmodule
